reg_dest_tracker: RTL and testbench
===================================

Name: reg_dest_tracker

Overview:
- Parametrised successor to the combinational write-destination mux of the MIPS datapath.
- Selects the destination register for each issued instruction and carries it through a STAGES-deep pipeline to write-back.
- Tracks in-flight destinations as a busy scoreboard and flags RAW hazards on two source operands for the control unit.
- Sits between instruction decode/control and the register-file write port.

Parameters:
- ADDR_W, 5, register address width.
- STAGES, 3, number of clock edges from issue to write-back presentation; legal range 1..8.
- LINK_REG, 31, destination for selector 10 (jal/link).
- ALT_REG, 30, destination for selector 11.
- NREGS, 2**ADDR_W, scoreboard width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- issue_valid  in  1  the current instruction writes a register.
- seletor_regdest  in  2  00 = rt, 01 = rd/offset field, 10 = LINK_REG, 11 = ALT_REG.
- rt  in  ADDR_W  instruction bits 20-16.
- rd  in  ADDR_W  instruction bits 15-11.
- stall  in  1  freeze pipeline; issue ignored.
- flush  in  1  kill all in-flight entries.
- src_a  in  ADDR_W  first source register to check.
- src_b  in  ADDR_W  second source register to check.
- regDest_output  out  ADDR_W  write-back destination (last stage).
- wb_valid  out  1  regDest_output is a real write this cycle.
- busy  out  NREGS  bit i is set when register i has a pending write in flight.
- hazard_a  out  1  src_a matches an in-flight destination.
- hazard_b  out  1  src_b matches an in-flight destination.

Behaviour:
Selection:
- Combinational pick of dest from seletor_regdest as listed under Ports.
- An entry is valid only if issue_valid = 1 and dest != 0. Writes to $zero are dropped, never tracked, and never produce wb_valid.

Pipeline:
- Stage registers s[0..STAGES-1], each holding {valid, addr}.
- On a rising edge with stall = 0 and flush = 0: s[0] loads {valid, dest}, and s[i] loads s[i-1] for i = 1..STAGES-1.
- regDest_output and wb_valid are driven directly from s[STAGES-1], with no extra register.
- Latency: an issue sampled at edge k appears on the outputs after edge k+STAGES-1 (STAGES=1 means visible right after the issue edge).
- With stall = 1, all stage registers hold and issue_valid is ignored. The output stage also holds, so wb_valid stays asserted; the register file is responsible for gating its own write with stall.

Flush:
- On the edge where flush = 1, every valid bit clears, including s[0], even if issue_valid = 1.
- flush has priority over stall and issue.
- Address fields may keep stale values; only valid bits are meaningful.

Scoreboard and hazards:
- busy[i] = OR over stages j of (s[j].valid and s[j].addr == i), combinational.
- A register held in several stages stays busy until its last copy leaves.
- busy excludes the entry presented at the output stage s[STAGES-1], because the register file writes it this cycle and forwarding is handled elsewhere. For STAGES = 1, busy is therefore always 0.
- hazard_a = (src_a != 0) and busy[src_a]; hazard_b is defined the same way for src_b. Both are combinational from the current state.
- The current-cycle issue is not included in busy or the hazard flags.

Reset:
- Asynchronous: all valid bits = 0 and all addr = 0 immediately, regardless of clk.
- Consequently regDest_output = 0, wb_valid = 0, busy = 0, hazard_a = hazard_b = 0.
- Reset mid-operation discards all in-flight entries.
- After reset deasserts, the first rising edge behaves as a normal issue edge.

Test Plan:
- STAGES=3. reset pulse asynchronously between edges -> all outputs 0 before the next edge.
- STAGES=3, issue sel=01, rd=8 at edge 1, idle afterwards:
  - busy[8] = 1 after edges 1-2.
  - After edge 3: regDest_output = 8, wb_valid = 1, busy[8] = 0.
  - After edge 4: wb_valid = 0.
- Back-to-back issues, one per edge:
  - sel=00 rt=5; sel=10 -> 31; sel=11 -> 30; sel=00 rt=0.
  - Required: outputs 5, 31, 30 in consecutive cycles with wb_valid = 1, then wb_valid = 0 for the $zero write.
  - busy[0] is never set.
- Hazard check: with dest 9 in s[0], src_a = 9, src_b = 0 -> hazard_a = 1, hazard_b = 0.
  - Apply stall for 2 edges -> state and hazard_a unchanged, and an issue of rd=4 during the stall is not captured.
- Flush with two in-flight entries (regs 7, 12) plus issue_valid (rd=3) on the same edge -> busy = 0 and wb_valid = 0 for the following STAGES cycles.
- STAGES=1 build: issue rd=6 -> regDest_output = 6, wb_valid = 1 right after that edge; busy stays 0 throughout.

Source files
------------

// File: rtl/reg_dest_tracker.sv
// reg_dest_tracker: write-destination select, pipeline to write-back,
// and in-flight busy scoreboard with RAW hazard flags on two sources.
module reg_dest_tracker #(
  parameter int ADDR_W   = 5,
  parameter int STAGES   = 3,
  parameter int LINK_REG = 31,
  parameter int ALT_REG  = 30,
  parameter int NREGS    = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issue_valid,
  input  logic [1:0]        seletor_regdest,
  input  logic [ADDR_W-1:0] rt,
  input  logic [ADDR_W-1:0] rd,
  input  logic              stall,
  input  logic              flush,
  input  logic [ADDR_W-1:0] src_a,
  input  logic [ADDR_W-1:0] src_b,
  output logic [ADDR_W-1:0] regDest_output,
  output logic              wb_valid,
  output logic [NREGS-1:0]  busy,
  output logic              hazard_a,
  output logic              hazard_b
);

  logic [ADDR_W-1:0]             dest;
  logic                          dest_ok;
  logic [STAGES-1:0]             vld_q, vld_d;
  logic [STAGES-1:0][ADDR_W-1:0] addr_q, addr_d;

  // Destination pick; $zero writes never become valid entries.
  always_comb begin
    dest = rt;
    unique case (seletor_regdest)
      2'b00: dest = rt;
      2'b01: dest = rd;
      2'b10: dest = ADDR_W'(LINK_REG);
      2'b11: dest = ADDR_W'(ALT_REG);
      default: dest = rt;
    endcase
    dest_ok = issue_valid && (dest != '0);
  end

  // Next stage state: flush kills all valids, stall holds, else shift.
  always_comb begin
    vld_d  = vld_q;
    addr_d = addr_q;
    if (flush) begin
      vld_d = '0;
    end else if (!stall) begin
      vld_d[0]  = dest_ok;
      addr_d[0] = dest;
      for (int i = 1; i < STAGES; i++) begin
        vld_d[i]  = vld_q[i-1];
        addr_d[i] = addr_q[i-1];
      end
    end
  end

  // Stage registers, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q  <= '0;
      addr_q <= '0;
    end else begin
      vld_q  <= vld_d;
      addr_q <= addr_d;
    end
  end

  // Busy covers every stage except the one being written back now.
  always_comb begin
    busy = '0;
    for (int j = 0; j < STAGES - 1; j++) begin
      if (vld_q[j]) busy[addr_q[j]] = 1'b1;
    end
    hazard_a = (src_a != '0) && busy[src_a];
    hazard_b = (src_b != '0) && busy[src_b];
  end

  assign regDest_output = addr_q[STAGES-1];
  assign wb_valid       = vld_q[STAGES-1];

endmodule

// File: tb/tb_reg_dest_tracker.sv
// tb_reg_dest_tracker: directed + random stimulus on STAGES=3 and
// STAGES=1 instances, checked against a queue scoreboard.
module tb_reg_dest_tracker;
  localparam int AW = 5;
  localparam int S  = 3;

  typedef struct packed {
    logic          v;
    logic [AW-1:0] a;
  } ent_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          issue_valid = 1'b0;
  logic [1:0]    sel = 2'b00;
  logic [AW-1:0] rt = '0, rd = '0;
  logic          stall = 1'b0, flush = 1'b0;
  logic [AW-1:0] src_a = '0, src_b = '0;

  logic [AW-1:0] dst3, dst1;
  logic          wb3, wb1;
  logic [31:0]   busy3, busy1;
  logic          ha3, hb3, ha1, hb1;

  int checks = 0;
  int failures = 0;
  ent_t q[$];
  ent_t e1;

  always #5 clk = ~clk;

  reg_dest_tracker #(.ADDR_W(AW), .STAGES(S)) u3 (
    .clk(clk), .reset(reset), .issue_valid(issue_valid),
    .seletor_regdest(sel), .rt(rt), .rd(rd), .stall(stall),
    .flush(flush), .src_a(src_a), .src_b(src_b),
    .regDest_output(dst3), .wb_valid(wb3), .busy(busy3),
    .hazard_a(ha3), .hazard_b(hb3)
  );

  reg_dest_tracker #(.ADDR_W(AW), .STAGES(1)) u1 (
    .clk(clk), .reset(reset), .issue_valid(issue_valid),
    .seletor_regdest(sel), .rt(rt), .rd(rd), .stall(stall),
    .flush(flush), .src_a(src_a), .src_b(src_b),
    .regDest_output(dst1), .wb_valid(wb1), .busy(busy1),
    .hazard_a(ha1), .hazard_b(hb1)
  );

  function automatic logic [AW-1:0] pick(
    input logic [1:0] s, input logic [AW-1:0] t, input logic [AW-1:0] d
  );
    case (s)
      2'b00:   return t;
      2'b01:   return d;
      2'b10:   return 5'd31;
      default: return 5'd30;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    ent_t o;
    logic [31:0] eb;
    int k0;
    o  = (q.size() == S) ? q[0] : '0;
    k0 = (q.size() == S) ? 1 : 0;
    eb = '0;
    for (int k = k0; k < q.size(); k++)
      if (q[k].v) eb[q[k].a] = 1'b1;
    chk("wb3", 32'(wb3), 32'(o.v));
    if (o.v) chk("dst3", 32'(dst3), 32'(o.a));
    chk("busy3", busy3, eb);
    chk("ha3", 32'(ha3), 32'((src_a != 0) && eb[src_a]));
    chk("hb3", 32'(hb3), 32'((src_b != 0) && eb[src_b]));
    chk("wb1", 32'(wb1), 32'(e1.v));
    if (e1.v) chk("dst1", 32'(dst1), 32'(e1.a));
    chk("busy1", busy1, 32'd0);
    chk("ha1", 32'(ha1), 32'd0);
    chk("hb1", 32'(hb1), 32'd0);
  endtask

  task automatic step(
    input logic iv, input logic [1:0] s, input logic [AW-1:0] t,
    input logic [AW-1:0] d, input logic st, input logic fl,
    input logic [AW-1:0] sa, input logic [AW-1:0] sb
  );
    ent_t n;
    issue_valid = iv; sel = s; rt = t; rd = d;
    stall = st; flush = fl; src_a = sa; src_b = sb;
    @(posedge clk);
    n.a = pick(s, t, d);
    n.v = iv && (n.a != 0);
    if (fl) begin
      foreach (q[k]) q[k].v = 1'b0;
      n.v = 1'b0;
      q.push_back(n);
      if (q.size() > S) void'(q.pop_front());
      e1 = '0;
    end else if (!st) begin
      q.push_back(n);
      if (q.size() > S) void'(q.pop_front());
      e1 = n;
    end
    #1 check_all();
  endtask

  task automatic idle(input int n, input logic [AW-1:0] sa,
                      input logic [AW-1:0] sb);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, sa, sb);
  endtask

  task automatic areset();
    #3 reset = 1'b1;
    #1 q.delete();
    e1 = '0;
    check_all();
    chk("rst_dst3", 32'(dst3), 32'd0);
    chk("rst_dst1", 32'(dst1), 32'd0);
    #1 reset = 1'b0;
  endtask

  initial begin
    e1 = '0;
    #2 check_all();
    chk("rst_dst3", 32'(dst3), 32'd0);
    repeat (2) @(posedge clk);
    #4 reset = 1'b0;

    step(1, 2'b01, 5'd0, 5'd8, 0, 0, 5'd8, 5'd0);
    idle(4, 5'd8, 5'd0);

    step(1, 2'b00, 5'd5, 5'd0, 0, 0, 5'd5, 5'd31);
    step(1, 2'b10, 5'd1, 5'd2, 0, 0, 5'd30, 5'd0);
    step(1, 2'b11, 5'd1, 5'd2, 0, 0, 5'd31, 5'd30);
    step(1, 2'b00, 5'd0, 5'd9, 0, 0, 5'd0, 5'd5);
    idle(4, 5'd0, 5'd0);

    step(1, 2'b01, 5'd0, 5'd9, 0, 0, 5'd9, 5'd0);
    chk("hz_a9", 32'(ha3), 32'd1);
    step(1, 2'b01, 5'd0, 5'd4, 1, 0, 5'd9, 5'd4);
    step(1, 2'b01, 5'd0, 5'd4, 1, 0, 5'd9, 5'd4);
    chk("stall_hz", 32'(ha3), 32'd1);
    chk("stall_nocap", 32'(busy3[4]), 32'd0);
    idle(3, 5'd9, 5'd4);

    step(1, 2'b01, 5'd0, 5'd7, 0, 0, 5'd7, 5'd12);
    step(1, 2'b01, 5'd0, 5'd12, 0, 0, 5'd7, 5'd12);
    step(1, 2'b01, 5'd0, 5'd3, 0, 1, 5'd7, 5'd3);
    chk("flush_busy", busy3, 32'd0);
    idle(S, 5'd7, 5'd12);

    step(1, 2'b01, 5'd0, 5'd6, 0, 0, 5'd6, 5'd0);
    chk("s1_dst", 32'(dst1), 32'd6);
    step(1, 2'b01, 5'd0, 5'd6, 1, 1, 5'd6, 5'd0);
    step(1, 2'b00, 5'd11, 5'd0, 0, 0, 5'd11, 5'd0);
    step(1, 2'b01, 5'd0, 5'd13, 0, 0, 5'd11, 5'd13);
    areset();
    step(1, 2'b01, 5'd0, 5'd14, 0, 0, 5'd14, 5'd0);
    idle(3, 5'd14, 5'd0);

    for (int i = 0; i < 80; i++) begin
      step($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
           5'($urandom_range(0, 31)), 5'($urandom_range(0, 7)),
           $urandom_range(0, 4) == 0, $urandom_range(0, 12) == 0,
           5'($urandom_range(0, 31)), 5'($urandom_range(0, 7)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
